div_unit: RTL

//  Multicycle signed 32-bit divider for the MIPS multicycle CPU; implements DIV.

---
 rtl/div_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multicycle signed divider (DIV) for the multicycle MIPS core.
// Restoring division on operand magnitudes, one quotient bit per clock,
// followed by a single sign-fix cycle. Hi = remainder, Lo = quotient.
//
// Handshake: the control unit pulses Start while the divider is idle. The
// divider answers with exactly one single-cycle pulse: Stop when Hi/Lo hold a
// fresh result, or DivZero when B was zero (Hi/Lo untouched). Start is only
// sampled in IDLE, and the Stop cycle is already IDLE, so back-to-back issue is
// allowed. Busy is high from the cycle after Start until Stop rises.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Stop,
  output logic             DivZero,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Held in a named enum register so checkers can bind to it hierarchically.
  state_t state;

  // Dividend shifts out MSB-first; quotient bits shift in at the LSB, so after
  // WIDTH steps this register holds the unsigned quotient.
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisorMag;
  logic [WIDTH:0]   rem;
  logic             signQ;
  logic             signR;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remSub;
  logic             remGe;
  logic [WIDTH-1:0] quotFixed;
  logic [WIDTH-1:0] remFixed;

  // Operand magnitudes, one restoring step, and final sign correction.
  // The most negative value maps to itself and is read as unsigned 2^(WIDTH-1).
  always_comb begin
    absA      = A[WIDTH-1] ? (~A + One) : A;
    absB      = B[WIDTH-1] ? (~B + One) : B;
    remShift  = {rem[WIDTH-1:0], dividend[WIDTH-1]};
    remGe     = (remShift >= {1'b0, divisorMag});
    remSub    = remShift - {1'b0, divisorMag};
    quotFixed = signQ ? (~dividend + One) : dividend;
    remFixed  = signR ? (~rem[WIDTH-1:0] + One) : rem[WIDTH-1:0];
  end

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      dividend   <= '0;
      divisorMag <= '0;
      rem        <= '0;
      signQ      <= 1'b0;
      signR      <= 1'b0;
      count      <= '0;
      Hi         <= '0;
      Lo         <= '0;
      Stop       <= 1'b0;
      DivZero    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Stop    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (B == '0) begin
              DivZero <= 1'b1;
            end else begin
              dividend   <= absA;
              divisorMag <= absB;
              signQ      <= A[WIDTH-1] ^ B[WIDTH-1];
              signR      <= A[WIDTH-1];
              rem        <= '0;
              count      <= '0;
              Busy       <= 1'b1;
              state      <= RUN;
            end
          end
        end
        RUN: begin
          if (remGe) begin
            rem      <= remSub;
            dividend <= {dividend[WIDTH-2:0], 1'b1};
          end else begin
            rem      <= remShift;
            dividend <= {dividend[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == LastCount) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Quotient truncates toward zero; remainder takes the dividend's sign.
          Lo    <= quotFixed;
          Hi    <= remFixed;
          state <= DONE;
        end
        DONE: begin
          Stop  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
